// File: rtl/eth_tx_stream.sv
// RGMII frame transmitter: wraps a valid/ready/last byte stream with preamble, fixed header,
// zero padding and CRC32 FCS, then enforces the inter-frame gap.
module eth_tx_stream #(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0208_BFB8_DA88,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned IFG       = 12,
    parameter int unsigned MAX_LEN   = 1500
) (
    input  logic        clk125,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        txctl,
    output logic [3:0]  txd,
    output logic        busy,
    output logic        err,
    output logic [15:0] frame_cnt
);

    localparam logic [31:0]  CrcPoly    = 32'hEDB8_8320;
    localparam logic [111:0] Hdr        = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  IfgLast    = 11'(IFG - 1);
    localparam logic [10:0]  MaxLen     = 11'(MAX_LEN);
    localparam logic [10:0]  MinPayload = 11'd46;

    typedef enum logic [2:0] {
        StIdle, StPre, StHdr, StData, StPad, StFcs, StGap, StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txbyte_q, txbyte_d;
    logic        txctl_q, txctl_d;
    logic        err_q, err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    // Set on underrun/overlength: FCS goes out non-inverted and the stream is drained after GAP.
    logic        abort_q, abort_d;

    logic [6:0]  hdr_msb;
    logic [7:0]  hdr_byte;
    logic [7:0]  fcs_raw;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
        end
        return r;
    endfunction

    assign hdr_msb  = 7'd111 - {cnt_q[3:0], 3'b000};
    assign hdr_byte = Hdr[hdr_msb -: 8];

    always_comb begin
        fcs_raw = 8'h00;
        unique case (cnt_q[1:0])
            2'd0: fcs_raw = crc_q[7:0];
            2'd1: fcs_raw = crc_q[15:8];
            2'd2: fcs_raw = crc_q[23:16];
            2'd3: fcs_raw = crc_q[31:24];
            default: fcs_raw = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        txbyte_d    = 8'h00;
        txctl_d     = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        abort_d     = abort_q;
        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    txbyte_d = 8'h55;
                    txctl_d  = 1'b1;
                    cnt_d    = 11'd1;
                    abort_d  = 1'b0;
                    state_d  = StPre;
                end
            end
            StPre: begin
                txctl_d = 1'b1;
                if (cnt_q == 11'd7) begin
                    txbyte_d = 8'hD5;
                    crc_d    = 32'hFFFF_FFFF;
                    cnt_d    = 11'd0;
                    state_d  = StHdr;
                end else begin
                    txbyte_d = 8'h55;
                    cnt_d    = cnt_q + 11'd1;
                end
            end
            StHdr: begin
                txctl_d  = 1'b1;
                txbyte_d = hdr_byte;
                crc_d    = crc_next(crc_q, hdr_byte);
                if (cnt_q == 11'd13) begin
                    cnt_d   = 11'd0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StData: begin
                txctl_d = 1'b1;
                if (s_valid) begin
                    txbyte_d = s_data;
                    crc_d    = crc_next(crc_q, s_data);
                    cnt_d    = cnt_q + 11'd1;
                    if (s_last) begin
                        if (cnt_q + 11'd1 < MinPayload) begin
                            state_d = StPad;
                        end else begin
                            cnt_d   = 11'd0;
                            state_d = StFcs;
                        end
                    end else if (cnt_q + 11'd1 == MaxLen) begin
                        cnt_d   = 11'd0;
                        abort_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = StFcs;
                    end
                end else begin
                    // Underrun: the first (non-inverted) FCS byte fills this slot so TX_EN never gaps.
                    txbyte_d = crc_q[7:0];
                    cnt_d    = 11'd1;
                    abort_d  = 1'b1;
                    err_d    = 1'b1;
                    state_d  = StFcs;
                end
            end
            StPad: begin
                txctl_d  = 1'b1;
                txbyte_d = 8'h00;
                crc_d    = crc_next(crc_q, 8'h00);
                if (cnt_q + 11'd1 == MinPayload) begin
                    cnt_d   = 11'd0;
                    state_d = StFcs;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StFcs: begin
                txctl_d  = 1'b1;
                txbyte_d = abort_q ? fcs_raw : ~fcs_raw;
                if (cnt_q == 11'd3) begin
                    cnt_d       = 11'd0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StGap;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StGap: begin
                if (cnt_q == IfgLast) begin
                    cnt_d   = 11'd0;
                    state_d = abort_q ? StDrain : StIdle;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StDrain: begin
                if (s_valid && s_last) begin
                    abort_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 11'd0;
            crc_q       <= 32'hFFFF_FFFF;
            txbyte_q    <= 8'h00;
            txctl_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            txbyte_q    <= txbyte_d;
            txctl_q     <= txctl_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            abort_q     <= abort_d;
        end
    end

    assign s_ready   = (state_q == StData) || (state_q == StDrain);
    assign busy      = (state_q != StIdle);
    assign txctl     = txctl_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;
    // DDR nibble mux: low nibble while clk125 is high, high nibble while low.
    assign txd       = clk125 ? txbyte_q[3:0] : txbyte_q[7:4];

endmodule

// File: tb/tb_eth_tx_stream.sv
// Bench for eth_tx_stream: directed frames, expected wire bytes queued at stimulus time and
// compared as the DDR nibbles are reassembled from txd.
module tb_eth_tx_stream;

    localparam int IfgCycles = 12;
    localparam int MaxLen    = 64;
    localparam logic [7:0] HdrBytes [14] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h02, 8'h08, 8'hBF, 8'hB8, 8'hDA, 8'h88,
        8'h88, 8'hB5
    };

    logic        clk125 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_last  = 1'b0;
    logic        s_ready, txctl, busy, err;
    logic [3:0]  txd;
    logic [15:0] frame_cnt;

    eth_tx_stream #(
        .IFG     (IfgCycles),
        .MAX_LEN (MaxLen)
    ) dut (
        .clk125    (clk125),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .txctl     (txctl),
        .txd       (txd),
        .busy      (busy),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    always #4 clk125 = ~clk125;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q [$];
    int         exp_len_q [$];
    logic [7:0] pl [$];

    int err_seen = 0;
    int last_gap = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    // Queue the wire image of a frame carrying pl[0..nsend-1]; aborted frames carry raw crc bytes.
    task automatic expect_frame(input int nsend, input bit aborted);
        logic [31:0] c;
        logic [7:0]  b;
        int          n;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(HdrBytes[i]);
            c = crc_upd(c, HdrBytes[i]);
        end
        for (int i = 0; i < nsend; i++) begin
            exp_q.push_back(pl[i]);
            c = crc_upd(c, pl[i]);
        end
        n = nsend;
        if (!aborted) begin
            while (n < 46) begin
                exp_q.push_back(8'h00);
                c = crc_upd(c, 8'h00);
                n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            b = 8'(c >> (8 * k));
            exp_q.push_back(aborted ? b : ~b);
        end
        exp_len_q.push_back(26 + n);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < 500) begin
            @(negedge clk125);
            t++;
        end
        check("ready_timeout", 32'(t < 500), 32'd1);
        @(negedge clk125);
    endtask

    task automatic send_frame(input int n, input int stop_after, input bit hold);
        for (int i = 0; i < n; i++) begin
            if (i == stop_after) begin
                s_valid = 1'b0;
                repeat (3) @(negedge clk125);
            end
            push_byte(pl[i], i == n - 1);
        end
        if (!hold) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp_len_q.size() != 0 || busy) && t < 4000) begin
            @(negedge clk125);
            t++;
        end
        check("done_timeout", 32'(t < 4000), 32'd1);
        repeat (2) @(negedge clk125);
    endtask

    // Monitor: rebuild each byte from both clock phases, score it and measure bursts and gaps.
    logic       m_ctl, m_err, m_rst, prev_ctl;
    logic [3:0] m_lo, m_hi;
    logic [7:0] m_exp;
    int         run, low_run;

    initial begin
        prev_ctl = 1'b0;
        run      = 0;
        low_run  = 0;
        forever begin
            @(posedge clk125);
            #1;
            m_ctl = txctl;
            m_lo  = txd;
            m_err = err;
            m_rst = rst_n;
            @(negedge clk125);
            #1;
            m_hi = txd;
            if (!m_rst || !rst_n) begin
                prev_ctl = 1'b0;
                run      = 0;
                low_run  = 0;
                continue;
            end
            if (m_err) err_seen++;
            if (m_ctl) begin
                if (!prev_ctl) last_gap = low_run;
                run++;
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    m_exp = exp_q.pop_front();
                    check("tx_byte", 32'({m_hi, m_lo}), 32'(m_exp));
                end
            end else begin
                if (prev_ctl) begin
                    check("burst_expected", 32'(exp_len_q.size() > 0), 32'd1);
                    if (exp_len_q.size() > 0) check("burst_len", 32'(run), 32'(exp_len_q.pop_front()));
                    run     = 0;
                    low_run = 0;
                end
                low_run++;
                check("idle_txd", 32'({m_hi, m_lo}), 32'd0);
            end
            prev_ctl = m_ctl;
        end
    end

    initial begin
        repeat (3) @(negedge clk125);
        #1;
        check("rst_txctl", 32'(txctl), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clk125);
        rst_n = 1'b1;

        // Minimum-length frame, no pad.
        pl.delete();
        for (int i = 0; i < 46; i++) pl.push_back(8'(i));
        expect_frame(46, 0);
        send_frame(46, -1, 0);
        wait_done();
        check("f1_fcnt", 32'(frame_cnt), 32'd1);
        check("f1_err", 32'(err_seen), 32'd0);

        // One byte, 45 bytes of pad.
        pl.delete();
        pl.push_back(8'hA5);
        expect_frame(1, 0);
        send_frame(1, -1, 0);
        wait_done();
        check("f2_fcnt", 32'(frame_cnt), 32'd2);

        // Back-to-back 60-byte frames with s_valid held high.
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(3 * i + 1));
        expect_frame(60, 0);
        expect_frame(60, 0);
        send_frame(60, -1, 1);
        send_frame(60, -1, 0);
        wait_done();
        check("b2b_gap", 32'(last_gap), 32'(IfgCycles));
        check("b2b_fcnt", 32'(frame_cnt), 32'd4);
        check("b2b_err", 32'(err_seen), 32'd0);

        // Underrun after 50 bytes, rest drained.
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i) ^ 8'h5A);
        expect_frame(50, 1);
        send_frame(100, 50, 0);
        wait_done();
        check("ur_err", 32'(err_seen), 32'd1);
        check("ur_fcnt", 32'(frame_cnt), 32'd5);

        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'(8'hC0 + i));
        expect_frame(10, 0);
        send_frame(10, -1, 0);
        wait_done();
        check("post_ur_fcnt", 32'(frame_cnt), 32'd6);
        check("post_ur_err", 32'(err_seen), 32'd1);

        // Overlength: 100 bytes offered, MAX_LEN sent, remainder drained.
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(7 * i));
        expect_frame(MaxLen, 1);
        send_frame(100, -1, 0);
        wait_done();
        check("ol_err", 32'(err_seen), 32'd2);
        check("ol_fcnt", 32'(frame_cnt), 32'd7);

        // s_last on the MAX_LEN-th byte is a normal end.
        pl.delete();
        for (int i = 0; i < MaxLen; i++) pl.push_back(8'(255 - i));
        expect_frame(MaxLen, 0);
        send_frame(MaxLen, -1, 0);
        wait_done();
        check("maxlen_err", 32'(err_seen), 32'd2);
        check("maxlen_fcnt", 32'(frame_cnt), 32'd8);

        // Asynchronous reset in the middle of DATA.
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i + 100));
        expect_frame(60, 0);
        for (int i = 0; i < 20; i++) push_byte(pl[i], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_txctl", 32'(txctl), 32'd0);
        check("mid_rst_ready", 32'(s_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_q.delete();
        exp_len_q.delete();
        repeat (3) @(negedge clk125);
        rst_n = 1'b1;

        pl.delete();
        for (int i = 0; i < 46; i++) pl.push_back(8'(i * 5));
        expect_frame(46, 0);
        send_frame(46, -1, 0);
        wait_done();
        check("post_rst_fcnt", 32'(frame_cnt), 32'd1);
        check("post_rst_err", 32'(err_seen), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
